uart_tx_scheduler: RTL and testbench

//  Sits between the CPU store path (data_mem write strobe/address/data) and uart_top's transmit registers.

---
 rtl/uart_tx_scheduler.sv | 120 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// CPU-store TX FIFO feeding the UART UDRT register; a store reaches udrt_load 2 cycles later on an idle UART.
// cpu_stall rises only for a UDRT store into a full FIFO with no same-cycle pop; one byte per UART frame.
module uart_tx_scheduler #(
    parameter int          DEPTH        = 8,
    parameter logic [31:0] UDRT_ADDR    = 32'd3,
    parameter int          BUSY_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_we,
    input  logic [31:0]            cpu_addr,
    input  logic [7:0]             cpu_wdata,
    output logic                   cpu_stall,
    input  logic                   uart_busy,
    output logic [7:0]             udrt,
    output logic                   udrt_load,
    output logic [$clog2(DEPTH):0] tx_level,
    output logic                   tx_empty,
    output logic                   tx_full,
    output logic                   tx_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [TW-1:0]   tmr;
    logic            hit;
    logic            push;
    logic            pop;

    assign tx_empty  = (tx_level == '0);
    assign tx_full   = (tx_level == LW'(DEPTH));
    assign hit       = cpu_we && (cpu_addr == UDRT_ADDR);
    assign pop       = (state == IDLE) && !tx_empty && !uart_busy;
    // A pop in the same cycle frees the slot, so a store into a full FIFO proceeds.
    assign push      = hit && (!tx_full || pop);
    assign cpu_stall = hit && tx_full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   tx_level <= tx_level + 1'b1;
                2'b01:   tx_level <= tx_level - 1'b1;
                default: tx_level <= tx_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            udrt      <= 8'h00;
            udrt_load <= 1'b0;
            tmr       <= '0;
            tx_err    <= 1'b0;
        end else begin
            udrt_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        udrt      <= mem[rd_ptr];
                        udrt_load <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    tmr   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (uart_busy) begin
                        state <= WAIT_DONE;
                    end else begin
                        tmr <= tmr + 1'b1;
                        // UART never acknowledged the load: the byte is abandoned.
                        if (tmr == TW'(BUSY_TIMEOUT - 1)) begin
                            tx_err <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!uart_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: vector table plus hand sequences for full/stall, timeout, wrap and reset.
module tb_uart_tx_scheduler;

    logic        clk;
    logic        rst;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_stall;
    logic        uart_busy;
    logic [7:0]  udrt;
    logic        udrt_load;
    logic [3:0]  tx_level;
    logic        tx_empty;
    logic        tx_full;
    logic        tx_err;

    logic        man_busy;
    logic        auto_uart;
    int          emu_cnt;
    logic [7:0]  obs[$];

    int          n_chk;
    int          n_err;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic        busy;
        logic [16:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[8];

    uart_tx_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_stall (cpu_stall),
        .uart_busy (uart_busy),
        .udrt      (udrt),
        .udrt_load (udrt_load),
        .tx_level  (tx_level),
        .tx_empty  (tx_empty),
        .tx_full   (tx_full),
        .tx_err    (tx_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Simple UART model: busy for three cycles after each load is seen.
    always @(negedge clk) begin
        if (udrt_load) begin
            obs.push_back(udrt);
            emu_cnt = 3;
        end else if (emu_cnt > 0) begin
            emu_cnt = emu_cnt - 1;
        end
    end

    assign uart_busy = auto_uart ? (emu_cnt != 0) : man_busy;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [7:0] wdata,
                                input logic busy, input logic [16:0] exp, input string name);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.busy = busy; v.exp = exp; v.name = name;
        return v;
    endfunction

    function automatic logic [16:0] outs();
        return {cpu_stall, udrt_load, udrt, tx_level, tx_empty, tx_full, tx_err};
    endfunction

    task automatic store(input logic [7:0] d);
        cpu_we = 1'b1; cpu_addr = 32'd3; cpu_wdata = d;
    endtask

    task automatic idle_bus();
        cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 8'h00;
    endtask

    initial begin
        int pushed;
        int maxl;
        n_chk = 0; n_err = 0;
        emu_cnt = 0;
        auto_uart = 1'b0; man_busy = 1'b0;
        rst = 1'b0;
        idle_bus();

        // {stall, load, udrt, level, empty, full, err}
        vecs[0] = mk(1'b1, 32'd3, 8'h41, 1'b0, {1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0}, "t1_store");
        vecs[1] = mk(1'b0, 32'd0, 8'h00, 1'b0, {1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0}, "t1_queued");
        vecs[2] = mk(1'b0, 32'd0, 8'h00, 1'b0, {1'b0, 1'b1, 8'h41, 4'd0, 1'b1, 1'b0, 1'b0}, "t1_load");
        vecs[3] = mk(1'b0, 32'd0, 8'h00, 1'b1, {1'b0, 1'b0, 8'h41, 4'd0, 1'b1, 1'b0, 1'b0}, "t1_pulse_end");
        vecs[4] = mk(1'b0, 32'd0, 8'h00, 1'b1, {1'b0, 1'b0, 8'h41, 4'd0, 1'b1, 1'b0, 1'b0}, "t1_busy");
        vecs[5] = mk(1'b1, 32'd4, 8'h55, 1'b0, {1'b0, 1'b0, 8'h41, 4'd0, 1'b1, 1'b0, 1'b0}, "t1_other_addr");
        vecs[6] = mk(1'b1, 32'd2, 8'h66, 1'b0, {1'b0, 1'b0, 8'h41, 4'd0, 1'b1, 1'b0, 1'b0}, "t1_other_addr2");
        vecs[7] = mk(1'b0, 32'd0, 8'h00, 1'b0, {1'b0, 1'b0, 8'h41, 4'd0, 1'b1, 1'b0, 1'b0}, "t1_ignored");

        repeat (2) @(negedge clk);
        chk("reset_vals", 32'(outs()), 32'({1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0}));
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cpu_we = vecs[i].we; cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata;
            man_busy = vecs[i].busy;
            #1;
            chk(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
        end
        chk("t1_one_load", obs.size(), 1);
        obs.delete();

        // Fill with the UART held busy, then stall the ninth store.
        man_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            store(8'(i));
        end
        @(negedge clk);
        store(8'h08);
        #1;
        chk("t2_full", 32'({tx_full, tx_level}), 32'({1'b1, 4'd8}));
        chk("t2_stall_a", 32'(cpu_stall), 32'd1);
        @(negedge clk);
        #1;
        chk("t2_stall_b", 32'(cpu_stall), 32'd1);
        @(negedge clk);
        cpu_addr = 32'd7;
        #1;
        chk("t2_other_no_stall", 32'(cpu_stall), 32'd0);
        @(negedge clk);
        store(8'h08);
        #1;
        chk("t2_stall_c", 32'(cpu_stall), 32'd1);
        @(negedge clk);
        man_busy = 1'b0;
        #1;
        chk("t3_pop_push_no_stall", 32'(cpu_stall), 32'd0);
        @(negedge clk);
        idle_bus();
        auto_uart = 1'b1;
        #1;
        chk("t3_level_kept", 32'(tx_level), 32'd8);
        chk("t3_first_load", 32'({udrt_load, udrt}), 32'({1'b1, 8'h00}));
        for (int c = 0; c < 400 && obs.size() < 9; c++) @(negedge clk);
        chk("t3_drain_count", obs.size(), 9);
        for (int i = 0; i < 9 && i < obs.size(); i++) chk($sformatf("t3_order_%0d", i), 32'(obs[i]), i);
        repeat (8) @(negedge clk);
        chk("t3_empty", 32'(tx_empty), 32'd1);

        // Busy never rises: timeout after 16 wait cycles, then the next byte goes out.
        auto_uart = 1'b0; man_busy = 1'b0;
        obs.delete();
        @(negedge clk);
        store(8'hA5);
        @(negedge clk);
        store(8'h5A);
        @(negedge clk);
        idle_bus();
        #1;
        chk("t4_load_a5", 32'({udrt_load, udrt}), 32'({1'b1, 8'hA5}));
        repeat (16) @(negedge clk);
        #1;
        chk("t4_err_not_yet", 32'(tx_err), 32'd0);
        @(negedge clk);
        #1;
        chk("t4_err_set", 32'({tx_err, udrt_load}), 32'({1'b1, 1'b0}));
        @(negedge clk);
        auto_uart = 1'b1;
        #1;
        chk("t4_next_load", 32'({udrt_load, udrt}), 32'({1'b1, 8'h5A}));
        repeat (10) @(negedge clk);
        chk("t4_err_sticky", 32'(tx_err), 32'd1);

        // Keep a few bytes in flight across pointer wrap-around.
        obs.delete();
        pushed = 0; maxl = 0;
        for (int c = 0; c < 400 && obs.size() < 12; c++) begin
            @(negedge clk);
            if (int'(tx_level) > maxl) maxl = int'(tx_level);
            if (pushed < 12 && (pushed < 3 || udrt_load)) begin
                store(8'h10 + 8'(pushed));
                pushed++;
            end else begin
                idle_bus();
            end
        end
        idle_bus();
        chk("t5_count", obs.size(), 12);
        chk("t5_max_level", 32'(maxl <= 3), 32'd1);
        for (int i = 0; i < 12 && i < obs.size(); i++) chk($sformatf("t5_order_%0d", i), 32'(obs[i]), 32'h10 + i);
        repeat (8) @(negedge clk);

        // Reset while the UART is mid-frame with three bytes queued.
        auto_uart = 1'b0; man_busy = 1'b0;
        @(negedge clk); store(8'hC0);
        @(negedge clk); store(8'hC1);
        @(negedge clk); store(8'hC2); man_busy = 1'b1;
        #1;
        chk("t6_load_c0", 32'({udrt_load, udrt}), 32'({1'b1, 8'hC0}));
        @(negedge clk); store(8'hC3);
        @(negedge clk); idle_bus();
        #1;
        chk("t6_queued", 32'(tx_level), 32'd3);
        rst = 1'b0;
        #1;
        chk("t6_reset_now", 32'(outs()), 32'({1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0}));
        obs.delete();
        @(negedge clk);
        rst = 1'b1; man_busy = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6_no_spurious_load", obs.size(), 0);
        store(8'h77);
        @(negedge clk); idle_bus();
        @(negedge clk);
        #1;
        chk("t6_fresh_load", 32'({udrt_load, udrt}), 32'({1'b1, 8'h77}));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
